// File: rtl/uibi_pkg.sv
// Shared definitions for the UIBI bus arbiter: bus mode encodings and FSM states.
package uibi_pkg;

   localparam logic [2:0] MODE_FULL = 3'b111;
   localparam logic [2:0] MODE_HALF = 3'b011;
   localparam logic [2:0] MODE_QUAR = 3'b001;
   localparam logic [2:0] MODE_NULL = 3'b000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/uibi_rr_arb.sv
// Combinational round-robin picker: the first requester at or after rr_ptr wins.
module uibi_rr_arb
   import uibi_pkg::*;
#(
   parameter int N_MASTERS = 2
) (
   input  logic [N_MASTERS-1:0]         req,
   input  logic [$clog2(N_MASTERS)-1:0] rr_ptr,
   output logic [N_MASTERS-1:0]         grant,
   output logic [$clog2(N_MASTERS)-1:0] grant_idx
);

   localparam int IW = $clog2(N_MASTERS);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int off = 0; off < N_MASTERS; off++) begin
         idx = (int'(rr_ptr) + off) % N_MASTERS;
         if (!found && req[IW'(idx)]) begin
            found             = 1'b1;
            grant[IW'(idx)]   = 1'b1;
            grant_idx         = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/uibi_arbiter.sv
// Multi-master / multi-slave UIBI bus arbiter with round-robin grant, address
// decode error and BUSY timeout. One transaction in flight at a time.
module uibi_arbiter
   import uibi_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int SLAVE_WIDTH = 4,
   parameter int N_MASTERS   = 2,
   parameter int N_SLAVES    = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [XLEN-1:0]             m_dat_i [N_MASTERS],
   output logic [XLEN-1:0]             m_dat_o [N_MASTERS],
   input  logic [XLEN-SLAVE_WIDTH-1:0] m_addr  [N_MASTERS],
   input  logic [SLAVE_WIDTH-1:0]      m_num   [N_MASTERS],
   input  logic [N_MASTERS-1:0]        m_req,
   input  logic [N_MASTERS-1:0]        m_wen,
   input  logic [2:0]                  m_mode  [N_MASTERS],
   output logic [N_MASTERS-1:0]        m_ready,
   output logic [N_MASTERS-1:0]        m_err,
   output logic [XLEN-1:0]             s_dat_o [N_SLAVES],
   input  logic [XLEN-1:0]             s_dat_i [N_SLAVES],
   output logic [XLEN-SLAVE_WIDTH-1:0] s_addr  [N_SLAVES],
   output logic [N_SLAVES-1:0]         s_req,
   output logic [N_SLAVES-1:0]         s_wen,
   output logic [2:0]                  s_mode  [N_SLAVES],
   input  logic [N_SLAVES-1:0]         s_ready,
   output state_e                      dbg_state
);

   localparam int IW = $clog2(N_MASTERS);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_e               state_q, state_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [N_MASTERS-1:0] arb_grant;
   logic [IW-1:0]        arb_idx;
   logic [SLAVE_WIDTH-1:0] sel;
   logic                 sel_valid;
   logic                 done;

   uibi_rr_arb #(.N_MASTERS(N_MASTERS)) u_rr_arb (
      .req       (m_req),
      .rr_ptr    (rr_ptr_q),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      done      = 1'b0;
      sel       = m_num[grant_q];
      sel_valid = (32'(sel) < N_SLAVES);
      m_ready   = '0;
      m_err     = '0;
      s_req     = '0;
      s_wen     = '0;
      for (int i = 0; i < N_MASTERS; i++) m_dat_o[i] = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         s_dat_o[j] = '0;
         s_addr[j]  = '0;
         s_mode[j]  = MODE_NULL;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (|arb_grant) begin
               grant_d = arb_idx;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (!sel_valid) begin
               m_ready[grant_q] = 1'b1;
               m_err[grant_q]   = 1'b1;
               m_dat_o[grant_q] = '1;
               done             = 1'b1;
            end else begin
               for (int j = 0; j < N_SLAVES; j++) begin
                  if (SLAVE_WIDTH'(j) == sel) begin
                     s_req[j]   = 1'b1;
                     s_wen[j]   = m_wen[grant_q];
                     s_addr[j]  = m_addr[grant_q];
                     s_mode[j]  = m_mode[grant_q];
                     s_dat_o[j] = m_dat_i[grant_q];
                     if (s_ready[j]) begin
                        m_ready[grant_q] = 1'b1;
                        m_dat_o[grant_q] = s_dat_i[j];
                        done             = 1'b1;
                     end
                  end
               end
               // s_ready in the last allowed cycle still completes normally
               if (!done && cnt_q == CW'(TIMEOUT - 1)) begin
                  m_ready[grant_q] = 1'b1;
                  m_err[grant_q]   = 1'b1;
                  m_dat_o[grant_q] = '1;
                  done             = 1'b1;
               end
            end
            if (done) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (grant_q == IW'(N_MASTERS - 1)) ? '0 : grant_q + IW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uibi_arbiter.sv
// Directed bench for uibi_arbiter (XLEN=64, 2 masters, 4 slaves, TIMEOUT=8).
module tb_uibi_arbiter;
   import uibi_pkg::*;

   localparam int XLEN = 64;
   localparam int SW   = 4;
   localparam int NM   = 2;
   localparam int NS   = 4;
   localparam int TO   = 8;
   localparam int AW   = XLEN - SW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] m_dat_i [NM];
   logic [XLEN-1:0] m_dat_o [NM];
   logic [AW-1:0]   m_addr  [NM];
   logic [SW-1:0]   m_num   [NM];
   logic [NM-1:0]   m_req = '0;
   logic [NM-1:0]   m_wen = '0;
   logic [2:0]      m_mode  [NM];
   logic [NM-1:0]   m_ready;
   logic [NM-1:0]   m_err;
   logic [XLEN-1:0] s_dat_o [NS];
   logic [XLEN-1:0] s_dat_i [NS];
   logic [AW-1:0]   s_addr  [NS];
   logic [NS-1:0]   s_req;
   logic [NS-1:0]   s_wen;
   logic [2:0]      s_mode  [NS];
   logic [NS-1:0]   s_ready = '0;
   state_e          dbg_state;

   int n_vec = 0;
   int n_err = 0;

   uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .N_MASTERS(NM), .N_SLAVES(NS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_addr(m_addr), .m_num(m_num),
      .m_req(m_req), .m_wen(m_wen), .m_mode(m_mode), .m_ready(m_ready), .m_err(m_err),
      .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_addr(s_addr), .s_req(s_req),
      .s_wen(s_wen), .s_mode(s_mode), .s_ready(s_ready), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      m_req = 2'b11;
      m_num[0] = 4'd1;
      tick(); tick(); samp();
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
      n_vec++; if (s_req !== 4'b0000) begin n_err++; $display("FAIL rst_s_req: got %b want 0000", s_req); end
      n_vec++; if (m_ready !== 2'b00 || m_err !== 2'b00) begin n_err++; $display("FAIL rst_m_ready: got %b/%b want 00/00", m_ready, m_err); end
      n_vec++; if (m_dat_o[0] !== 64'h0 || s_dat_o[1] !== 64'h0) begin n_err++; $display("FAIL rst_data: got %0h/%0h want 0/0", m_dat_o[0], s_dat_o[1]); end
      tick();
      m_req = 2'b00;
      rst_n = 1'b1;
      samp();
   endtask

   task automatic test_read();
      tick();
      m_req[0] = 1'b1; m_num[0] = 4'd2; m_wen[0] = 1'b0; m_addr[0] = 60'h123;
      samp();
      n_vec++; if (s_req !== 4'b0000) begin n_err++; $display("FAIL rd_idle_s_req: got %b want 0000", s_req); end
      for (int k = 0; k < 3; k++) begin
         tick(); samp();
         n_vec++; if (s_req !== 4'b0100 || m_ready !== 2'b00) begin n_err++; $display("FAIL rd_wait%0d: got s_req %b m_ready %b want 0100 00", k, s_req, m_ready); end
      end
      n_vec++; if (s_addr[2] !== 60'h123) begin n_err++; $display("FAIL rd_addr: got %0h want 123", s_addr[2]); end
      tick();
      s_ready[2] = 1'b1; s_dat_i[2] = 64'hDEADBEEF;
      samp();
      n_vec++; if (m_ready !== 2'b01 || m_err !== 2'b00) begin n_err++; $display("FAIL rd_done: got m_ready %b m_err %b want 01 00", m_ready, m_err); end
      n_vec++; if (m_dat_o[0] !== 64'h0000_0000_DEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %0h want deadbeef", m_dat_o[0]); end
      n_vec++; if (m_dat_o[1] !== 64'h0) begin n_err++; $display("FAIL rd_other_data: got %0h want 0", m_dat_o[1]); end
      tick();
      m_req = 2'b00; s_ready = '0;
      samp();
      n_vec++; if (m_ready !== 2'b00 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rd_one_pulse: got m_ready %b state %0d want 00 0", m_ready, dbg_state); end
   endtask

   task automatic test_bad_slave();
      tick();
      m_req[1] = 1'b1; m_num[1] = 4'd7;
      samp();
      tick(); samp();
      n_vec++; if (s_req !== 4'b0000) begin n_err++; $display("FAIL bad_s_req: got %b want 0000", s_req); end
      n_vec++; if (m_ready !== 2'b10 || m_err !== 2'b10) begin n_err++; $display("FAIL bad_resp: got m_ready %b m_err %b want 10 10", m_ready, m_err); end
      n_vec++; if (m_dat_o[1] !== {XLEN{1'b1}}) begin n_err++; $display("FAIL bad_data: got %0h want all ones", m_dat_o[1]); end
      tick();
      m_req = 2'b00;
      samp();
      n_vec++; if (dbg_state !== ST_IDLE || m_ready !== 2'b00) begin n_err++; $display("FAIL bad_return: got state %0d m_ready %b want 0 00", dbg_state, m_ready); end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0]   exp_rdy;
      logic [XLEN-1:0] exp_dat;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) begin
            m_req = 2'b11; m_num[0] = 4'd1; m_num[1] = 4'd3; m_wen = 2'b00;
            s_ready = 4'b1111; s_dat_i[1] = 64'h11; s_dat_i[3] = 64'h33;
         end
         samp();
         exp_rdy = (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10);
         n_vec++; if (m_ready !== exp_rdy) begin n_err++; $display("FAIL rr_cycle%0d: got m_ready %b want %b", k, m_ready, exp_rdy); end
         if (k % 4 == 1) begin
            exp_dat = 64'h11;
            n_vec++; if (m_dat_o[0] !== exp_dat || s_req !== 4'b0010) begin n_err++; $display("FAIL rr_m0_%0d: got %0h s_req %b want %0h 0010", k, m_dat_o[0], s_req, exp_dat); end
         end else if (k % 4 == 3) begin
            exp_dat = 64'h33;
            n_vec++; if (m_dat_o[1] !== exp_dat || s_req !== 4'b1000) begin n_err++; $display("FAIL rr_m1_%0d: got %0h s_req %b want %0h 1000", k, m_dat_o[1], s_req, exp_dat); end
         end
      end
      tick();
      m_req = 2'b00; s_ready = '0;
      samp();
   endtask

   task automatic test_timeout();
      int hi_cnt;
      hi_cnt = 0;
      tick();
      m_req[0] = 1'b1; m_num[0] = 4'd1;
      samp();
      for (int k = 0; k < 9; k++) begin
         tick();
         if (k == 8) m_req = 2'b00;
         samp();
         if (s_req[1]) hi_cnt++;
         if (k < 7) begin
            n_vec++; if (m_ready !== 2'b00) begin n_err++; $display("FAIL to_wait%0d: got m_ready %b want 00", k, m_ready); end
         end else if (k == 7) begin
            n_vec++; if (m_ready !== 2'b01 || m_err !== 2'b01) begin n_err++; $display("FAIL to_resp: got m_ready %b m_err %b want 01 01", m_ready, m_err); end
            n_vec++; if (m_dat_o[0] !== {XLEN{1'b1}}) begin n_err++; $display("FAIL to_data: got %0h want all ones", m_dat_o[0]); end
         end else begin
            n_vec++; if (dbg_state !== ST_IDLE || s_req !== 4'b0000) begin n_err++; $display("FAIL to_idle: got state %0d s_req %b want 0 0000", dbg_state, s_req); end
         end
      end
      n_vec++; if (hi_cnt != TO) begin n_err++; $display("FAIL to_s_req_cycles: got %0d want %0d", hi_cnt, TO); end
   endtask

   task automatic test_ready_at_timeout();
      tick();
      m_req[1] = 1'b1; m_num[1] = 4'd0;
      samp();
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 7) begin s_ready[0] = 1'b1; s_dat_i[0] = 64'h0000_1234_5678_9ABC; end
         samp();
      end
      n_vec++; if (m_ready !== 2'b10 || m_err !== 2'b00) begin n_err++; $display("FAIL prio_resp: got m_ready %b m_err %b want 10 00", m_ready, m_err); end
      n_vec++; if (m_dat_o[1] !== 64'h0000_1234_5678_9ABC) begin n_err++; $display("FAIL prio_data: got %0h want 123456789abc", m_dat_o[1]); end
      tick();
      m_req = 2'b00; s_ready = '0;
      samp();
   endtask

   task automatic test_write();
      tick();
      m_req[0] = 1'b1; m_num[0] = 4'd3; m_wen[0] = 1'b1; m_mode[0] = MODE_HALF;
      m_dat_i[0] = 64'hA5A5_0123_4567_89AB; m_addr[0] = 60'h0AB_CDEF_0123_4567;
      samp();
      tick(); samp();
      n_vec++; if (s_req !== 4'b1000 || s_wen !== 4'b1000) begin n_err++; $display("FAIL wr_req: got s_req %b s_wen %b want 1000 1000", s_req, s_wen); end
      n_vec++; if (s_mode[3] !== 3'b011) begin n_err++; $display("FAIL wr_mode: got %b want 011", s_mode[3]); end
      n_vec++; if (s_dat_o[3] !== 64'hA5A5_0123_4567_89AB) begin n_err++; $display("FAIL wr_data: got %0h want a5a50123456789ab", s_dat_o[3]); end
      n_vec++; if (s_addr[3] !== 60'h0AB_CDEF_0123_4567) begin n_err++; $display("FAIL wr_addr: got %0h want abcdef01234567", s_addr[3]); end
      n_vec++; if (s_dat_o[0] !== 64'h0 || s_mode[0] !== 3'b000) begin n_err++; $display("FAIL wr_other_slave: got %0h %b want 0 000", s_dat_o[0], s_mode[0]); end
      tick();
      s_ready[3] = 1'b1;
      samp();
      n_vec++; if (m_ready !== 2'b01 || m_err !== 2'b00) begin n_err++; $display("FAIL wr_done: got m_ready %b m_err %b want 01 00", m_ready, m_err); end
      tick();
      m_req = 2'b00; m_wen = 2'b00; s_ready = '0;
      samp();
   endtask

   task automatic test_reset_mid_busy();
      tick();
      m_req[1] = 1'b1; m_num[1] = 4'd2;
      samp();
      tick(); samp();
      n_vec++; if (s_req !== 4'b0100) begin n_err++; $display("FAIL rb_busy: got s_req %b want 0100", s_req); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (s_req !== 4'b0000 || m_ready !== 2'b00) begin n_err++; $display("FAIL rb_async_drop: got s_req %b m_ready %b want 0000 00", s_req, m_ready); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rb_async_state: got %0d want 0", dbg_state); end
      m_num[0] = 4'd0; m_req = 2'b11; s_ready[0] = 1'b1; s_dat_i[0] = 64'h77;
      tick(); tick(); samp();
      n_vec++; if (s_req !== 4'b0000 || m_ready !== 2'b00) begin n_err++; $display("FAIL rb_held: got s_req %b m_ready %b want 0000 00", s_req, m_ready); end
      tick();
      rst_n = 1'b1;
      samp();
      tick(); samp();
      n_vec++; if (m_ready !== 2'b01 || s_req !== 4'b0001) begin n_err++; $display("FAIL rb_m0_first: got m_ready %b s_req %b want 01 0001", m_ready, s_req); end
      n_vec++; if (m_dat_o[0] !== 64'h77) begin n_err++; $display("FAIL rb_data: got %0h want 77", m_dat_o[0]); end
      tick();
      m_req = 2'b00; s_ready = '0;
      samp();
   endtask

   initial begin
      for (int i = 0; i < NM; i++) begin
         m_dat_i[i] = '0; m_addr[i] = '0; m_num[i] = '0; m_mode[i] = MODE_NULL;
      end
      for (int j = 0; j < NS; j++) s_dat_i[j] = '0;
      test_reset();
      test_read();
      test_bad_slave();
      test_round_robin();
      test_timeout();
      test_ready_at_timeout();
      test_write();
      test_reset_mid_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
